// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and holds the IF/ID register.
// Absorbs the memory's one-cycle read latency and supports decode stall plus branch/jump flush.
module instruction_fetch_unit #(
   parameter int                     PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branchTaken,
   input  logic [PC_WIDTH-1:0] branchTarget,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jumpTarget,
   input  logic [31:0]         instructionOut,
   output logic [PC_WIDTH-1:0] instructionAdress,
   output logic [31:0]         ifIdInstruction,
   output logic [PC_WIDTH-1:0] ifIdPc,
   output logic [PC_WIDTH-1:0] ifIdPcPlus4,
   output logic                ifIdValid
);

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_in_flight_pc;
   logic                r_in_flight_valid;
   logic [31:0]         r_if_id_instruction;
   logic [PC_WIDTH-1:0] r_if_id_pc;
   logic [PC_WIDTH-1:0] r_if_id_pc_plus4;
   logic                r_if_id_valid;

   logic                w_redirect;
   logic [PC_WIDTH-1:0] w_target;
   logic [PC_WIDTH-1:0] w_target_aligned;

   assign w_redirect       = branchTaken | jump;
   assign w_target         = branchTaken ? branchTarget : jumpTarget;
   assign w_target_aligned = {w_target[PC_WIDTH-1:2], 2'b00};

   // While stalled, re-present the in-flight address so the memory keeps returning the held word.
   assign instructionAdress = (stall && !w_redirect) ? r_in_flight_pc : r_pc;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc                <= RESET_PC;
         r_in_flight_pc      <= '0;
         r_in_flight_valid   <= 1'b0;
         r_if_id_instruction <= '0;
         r_if_id_pc          <= '0;
         r_if_id_pc_plus4    <= '0;
         r_if_id_valid       <= 1'b0;
      end else if (w_redirect) begin
         r_pc              <= w_target_aligned;
         r_in_flight_valid <= 1'b0;
         r_if_id_valid     <= 1'b0;
      end else if (!stall) begin
         r_in_flight_pc      <= r_pc;
         r_in_flight_valid   <= 1'b1;
         r_pc                <= r_pc + PC_STEP;
         r_if_id_instruction <= instructionOut;
         r_if_id_pc          <= r_in_flight_pc;
         r_if_id_pc_plus4    <= r_in_flight_pc + PC_STEP;
         r_if_id_valid       <= r_in_flight_valid;
      end
   end

   assign ifIdInstruction = r_if_id_instruction;
   assign ifIdPc          = r_if_id_pc;
   assign ifIdPcPlus4     = r_if_id_pc_plus4;
   assign ifIdValid       = r_if_id_valid;

endmodule
